// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving one external full-adder cell
// Optional subtract mode under SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] s_shift;
    logic             sub_in;
    logic             run;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign run = (state_q == S_RUN);

    // Partial result: s_shift is the accumulated value including the bit on the cell this cycle.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_shift = fa_sum;
        end else begin : g_wn
            logic [WIDTH-2:0] s_sr_q;
            assign s_shift = {fa_sum, s_sr_q};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_sr_q <= '0;
                end else if (run) begin
                    s_sr_q <= s_shift[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_cin  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    sub_d   = sub_in;
                    carry_d = sub_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                fa_a    = a_sr_q[0];
                fa_b    = b_sr_q[0] ^ sub_q;
                fa_cin  = carry_q;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = s_shift;
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - vector table plus scoreboard bench for serial_add_ctrl
// Subtract vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

    // The external full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
        int           glitch;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    vec_t         vecs[$];
    res_t         sbq[$];
    res_t         mon_r;
    logic [W-1:0] held_sum;
    logic         held_c;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                chk1("unexpected_done", done, 1'b0);
            end else begin
                mon_r = sbq.pop_front();
                chkw("sum", sum, mon_r.s);
                chk1("cout", cout, mon_r.c);
                held_sum = mon_r.s;
                held_c   = mon_r.c;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk1("idle_timeout", busy, 1'b0);
    endtask

    // Entered and left at a negedge in IDLE; checks each RUN bit against the bench's own carry chain.
    task automatic run_op(input vec_t v);
        logic c, bb;
        wait_idle();
        a     = v.a;
        b     = v.b;
`ifdef SERIAL_ADD_SUB_EN
        sub   = v.sub;
`endif
        start = 1'b1;
        sbq.push_back('{s: v.es, c: v.ec});
        c = v.sub;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            if (i == v.glitch) begin
                a     = '1;
                b     = '1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            bb = v.b[i] ^ v.sub;
            chk1("run_busy", busy, 1'b1);
            chk1("run_done", done, 1'b0);
            chk1("fa_a", fa_a, v.a[i]);
            chk1("fa_b", fa_b, bb);
            chk1("fa_cin", fa_cin, c);
            chkw("sum_hold", sum, held_sum);
            c = (v.a[i] & bb) | (v.a[i] & c) | (bb & c);
        end
        start = 1'b0;
        @(negedge clk);
        chk1("done_busy", busy, 1'b1);
        chk1("done_pulse", done, 1'b1);
        chk1("fa_idle", fa_a | fa_b | fa_cin, 1'b0);
        @(negedge clk);
        chk1("post_busy", busy, 1'b0);
        chk1("post_done", done, 1'b0);
        chkw("post_sum", sum, v.es);
    endtask

    initial begin
        logic saw_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub      = 1'b0;
`endif
        held_sum = '0;
        held_c   = 1'b0;

        vecs.push_back('{a: 8'h3C, b: 8'h45, sub: 1'b0, es: 8'h81, ec: 1'b0, glitch: -1});
        vecs.push_back('{a: 8'h10, b: 8'h20, sub: 1'b0, es: 8'h30, ec: 1'b0, glitch: 2});
        vecs.push_back('{a: 8'hFF, b: 8'h01, sub: 1'b0, es: 8'h00, ec: 1'b1, glitch: -1});
        vecs.push_back('{a: 8'h00, b: 8'h00, sub: 1'b0, es: 8'h00, ec: 1'b0, glitch: -1});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, sub: 1'b0, es: 8'hFE, ec: 1'b1, glitch: -1});
        vecs.push_back('{a: 8'h80, b: 8'h80, sub: 1'b0, es: 8'h00, ec: 1'b1, glitch: -1});
        vecs.push_back('{a: 8'h55, b: 8'hAA, sub: 1'b0, es: 8'hFF, ec: 1'b0, glitch: -1});
        vecs.push_back('{a: 8'h7F, b: 8'h01, sub: 1'b0, es: 8'h80, ec: 1'b0, glitch: 5});
        vecs.push_back('{a: 8'hC3, b: 8'h3E, sub: 1'b0, es: 8'h01, ec: 1'b1, glitch: -1});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{a: 8'h10, b: 8'h01, sub: 1'b1, es: 8'h0F, ec: 1'b1, glitch: -1});
        vecs.push_back('{a: 8'h01, b: 8'h02, sub: 1'b1, es: 8'hFF, ec: 1'b0, glitch: -1});
        vecs.push_back('{a: 8'h00, b: 8'h00, sub: 1'b1, es: 8'h00, ec: 1'b1, glitch: -1});
`endif

        // Reset held with start toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
            a     = W'($urandom);
            b     = W'($urandom);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chkw("rst_sum", sum, '0);
            chk1("rst_cout", cout, 1'b0);
            chk1("rst_fa", fa_a | fa_b | fa_cin, 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("idle_after_rst", busy, 1'b0);
        end

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-to-back with start held high: second accept on the edge ending E0+W+2.
        wait_idle();
        a     = 8'hFF;
        b     = 8'h01;
        start = 1'b1;
        sbq.push_back('{s: 8'h00, c: 1'b1});
        sbq.push_back('{s: 8'h00, c: 1'b1});
        repeat (W + 1) @(negedge clk);
        chk1("b2b_done1", done, 1'b1);
        @(negedge clk);
        chk1("b2b_gap", busy, 1'b0);
        @(negedge clk);
        chk1("b2b_accept2", busy, 1'b1);
        start = 1'b0;
        repeat (W) @(negedge clk);
        chk1("b2b_done2", done, 1'b1);
        @(negedge clk);
        chk1("b2b_idle", busy, 1'b0);

        // Abort mid-RUN with a nonzero result held.
        run_op(vecs[0]);
        a     = 8'h3C;
        b     = 8'h45;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chkw("abort_sum", sum, '0);
        chk1("abort_cout", cout, 1'b0);
        chk1("abort_fa", fa_a | fa_b | fa_cin, 1'b0);
        held_sum = '0;
        held_c   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        chk1("abort_no_done", saw_done, 1'b0);
        run_op(vecs[0]);

        chkw("sb_empty", W'(sbq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
